mem_dump_streamer: RTL

- Sequential reader that sweeps a window of the data memory and streams each word out over a valid/ready interface. It is the read-side counterpart to the CPU's store path.
- Replaces simulation-only memory printing with a synthesizable scan-out. It sits beside data_memory on a dedicated read port and feeds a debug or UART sink.
- Software (bench or debug controller) pulses start with a base byte address and a word count. The block reports busy and done.

---
 rtl/mem_dump_pkg.sv | 18 +
 rtl/mem_dump_addr_gen.sv | 54 +++++
 rtl/mem_dump_streamer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_dump_pkg.sv
// Shared types and constants for the memory dump streamer and its address generator.
package mem_dump_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_CNT_W  = 16;
  localparam int WORD_BYTES = 4;
  localparam int OFS_W      = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_FIN  = 3'd4
  } state_e;

endpackage

// File: rtl/mem_dump_addr_gen.sv
// Sweep address and remaining-word counter; the word address wraps silently at the
// top of the byte address space.
module mem_dump_addr_gen
  import mem_dump_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W-1:0] addr_d_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;

  // Load aligns the base; step advances one word.
  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    if (load_i) begin
      addr_d      = {base_i[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
      remaining_d = count_i;
    end else if (step_i) begin
      addr_d      = addr_q + ADDR_W'(WORD_BYTES);
      remaining_d = remaining_q - CNT_W'(1);
    end else begin
      addr_d      = addr_q;
      remaining_d = remaining_q;
    end
  end

  // Address and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
    end else begin
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
    end
  end

  assign addr_o   = addr_q;
  assign addr_d_o = addr_d;
  assign last_o   = (remaining_q == CNT_W'(1));

endmodule

// File: rtl/mem_dump_streamer.sv
// Sweeps a window of data memory and streams each word out over valid/ready,
// with busy/done status and abort.
module mem_dump_streamer
  import mem_dump_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int RD_LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_s, addr_next_s;
  logic              last_s;
  logic              load_s, step_s, capture_s;

  logic              busy_q, done_q, mem_rd_en_q, out_valid_q, out_last_q;
  logic [ADDR_W-1:0] mem_addr_q, out_addr_q;
  logic [DATA_W-1:0] out_data_q;

  assign load_s    = (state_q == S_IDLE) && start;
  assign step_s    = (state_q == S_SEND) && out_valid_q && out_ready;
  assign capture_s = ((state_q == S_READ) && (RD_LAT == 0)) || (state_q == S_WAIT);

  mem_dump_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load_s),
    .base_i   (base_addr),
    .count_i  (word_count),
    .step_i   (step_s),
    .addr_o   (addr_s),
    .addr_d_o (addr_next_s),
    .last_o   (last_s)
  );

  // Next state; abort beats everything except IDLE, where start wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (word_count == CNT_W'(0)) ? S_FIN : S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (abort) begin
          state_d = S_FIN;
        end else begin
          state_d = (RD_LAT == 0) ? S_SEND : S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_FIN;
        end else begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_d = S_FIN;
        end else if (step_s) begin
          state_d = last_s ? S_FIN : S_READ;
        end else begin
          state_d = S_SEND;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register and outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_FIN);
      mem_rd_en_q <= (state_d == S_READ);
      out_valid_q <= (state_d == S_SEND);
      if (state_d == S_READ) begin
        mem_addr_q <= addr_next_s;
      end
    end
  end

  // Beat register; held stable through SEND because capture only fires in READ/WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
      out_addr_q <= '0;
      out_last_q <= 1'b0;
    end else if (capture_s) begin
      out_data_q <= mem_rdata;
      out_addr_q <= addr_s;
      out_last_q <= last_s;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;

endmodule
